// File: rtl/mtsp_sf_wb_queue_pkg.sv
// Shared constants and the write-back entry layout for the SF write-back queue.
package mtsp_sf_wb_queue_pkg;
  localparam int SF_WB_DEPTH = 4;
  localparam int SF_DST_W    = 6;

  typedef struct packed {
    logic                phase;
    logic [SF_DST_W-1:0] dst;
    logic [31:0]         data;
  } sf_wb_entry_t;
endpackage

// File: rtl/mtsp_sf_tag_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is read straight from storage.
module mtsp_sf_tag_fifo
  import mtsp_sf_wb_queue_pkg::*;
#(
  parameter int WIDTH = SF_DST_W,
  parameter int DEPTH = SF_WB_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still safe.
  assign do_push = push & (~full | do_pop);
  assign wr_d    = wr_q + {{AW{1'b0}}, do_push};
  assign rd_d    = rd_q + {{AW{1'b0}}, do_pop};
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/mtsp_sf_wb_queue.sv
// Pairs SF results with destinations recorded at issue and queues them for register write-back.
module mtsp_sf_wb_queue
  import mtsp_sf_wb_queue_pkg::*;
#(
  parameter int DEPTH = SF_WB_DEPTH,
  parameter int DST_W = SF_DST_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       ISSUE_EN,
  input  logic [DST_W-1:0] ISSUE_DST0,
  input  logic [DST_W-1:0] ISSUE_DST1,
  output logic             ISSUE_STALL,
  input  logic [1:0]       RES_EN,
  input  logic [31:0]      RES_DATA,
  output logic             WB_VALID,
  input  logic             WB_READY,
  output logic             WB_PHASE,
  output logic [DST_W-1:0] WB_DST,
  output logic [31:0]      WB_DATA,
  output logic             ERR
);
  localparam int OW    = $clog2(DEPTH) + 1;
  // Same layout as sf_wb_entry_t, sized by this instance's DST_W.
  localparam int ENT_W = 1 + DST_W + 32;

  logic [OW-1:0]    outs_q, outs_d;
  logic             err_q, err_d;
  logic [1:0]       issue_acc, res_ok, tag_empty, tag_full;
  logic [DST_W-1:0] tag0, tag1;
  logic [ENT_W-1:0] res_din, res_head;
  logic             res_push, res_empty, res_full, wb_fire;
  logic             issue_drop, res_drop;

  assign ISSUE_STALL = (outs_q > OW'(DEPTH - 2));
  assign issue_acc   = ISSUE_EN & ~{2{ISSUE_STALL}} & ~tag_full;
  assign issue_drop  = |(ISSUE_EN & ~issue_acc);

  // Phase 0 wins when both result enables are set; phase 1 is discarded.
  assign res_ok[0] = RES_EN[0] & ~tag_empty[0];
  assign res_ok[1] = RES_EN[1] & ~RES_EN[0] & ~tag_empty[1];
  assign res_push  = |res_ok;
  assign res_din   = {res_ok[1], (res_ok[1] ? tag1 : tag0), RES_DATA};
  assign res_drop  = (&RES_EN) | (RES_EN[0] & tag_empty[0])
                   | (RES_EN[1] & ~RES_EN[0] & tag_empty[1]) | (res_push & res_full);

  assign WB_VALID = ~res_empty;
  assign wb_fire  = WB_VALID & WB_READY;
  assign WB_PHASE = res_empty ? 1'b0 : res_head[ENT_W-1];
  assign WB_DST   = res_empty ? '0 : res_head[32 +: DST_W];
  assign WB_DATA  = res_empty ? '0 : res_head[31:0];
  assign ERR      = err_q;

  always_comb begin
    outs_d = outs_q + OW'(issue_acc[0]) + OW'(issue_acc[1]) - OW'(wb_fire);
    err_d  = err_q | issue_drop | res_drop;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      outs_q <= '0;
      err_q  <= 1'b0;
    end else begin
      outs_q <= outs_d;
      err_q  <= err_d;
    end
  end

  mtsp_sf_tag_fifo #(.WIDTH(DST_W), .DEPTH(DEPTH)) u_tag0 (
    .clk(CLK), .rst_n(nRST), .push(issue_acc[0]), .pop(res_ok[0]), .din(ISSUE_DST0),
    .dout(tag0), .empty(tag_empty[0]), .full(tag_full[0])
  );

  mtsp_sf_tag_fifo #(.WIDTH(DST_W), .DEPTH(DEPTH)) u_tag1 (
    .clk(CLK), .rst_n(nRST), .push(issue_acc[1]), .pop(res_ok[1]), .din(ISSUE_DST1),
    .dout(tag1), .empty(tag_empty[1]), .full(tag_full[1])
  );

  mtsp_sf_tag_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_res (
    .clk(CLK), .rst_n(nRST), .push(res_push), .pop(wb_fire), .din(res_din),
    .dout(res_head), .empty(res_empty), .full(res_full)
  );
endmodule

// File: tb/tb_mtsp_sf_wb_queue.sv
// Directed bench for the SF write-back queue: pairing, ordering, back-pressure, errors, reset.
module tb_mtsp_sf_wb_queue;
  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  ISSUE_EN;
  logic [5:0]  ISSUE_DST0, ISSUE_DST1;
  logic        ISSUE_STALL;
  logic [1:0]  RES_EN;
  logic [31:0] RES_DATA;
  logic        WB_VALID, WB_READY, WB_PHASE, ERR;
  logic [5:0]  WB_DST;
  logic [31:0] WB_DATA;

  int errors = 0;
  int checks = 0;

  mtsp_sf_wb_queue #(.DEPTH(4), .DST_W(6)) dut (
    .CLK(CLK), .nRST(nRST), .ISSUE_EN(ISSUE_EN), .ISSUE_DST0(ISSUE_DST0),
    .ISSUE_DST1(ISSUE_DST1), .ISSUE_STALL(ISSUE_STALL), .RES_EN(RES_EN),
    .RES_DATA(RES_DATA), .WB_VALID(WB_VALID), .WB_READY(WB_READY),
    .WB_PHASE(WB_PHASE), .WB_DST(WB_DST), .WB_DATA(WB_DATA), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0; ISSUE_EN = 2'b00; ISSUE_DST0 = '0; ISSUE_DST1 = '0;
    RES_EN = 2'b00; RES_DATA = '0; WB_READY = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (WB_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", WB_VALID); end
    checks++; if (WB_PHASE !== 1'b0) begin errors++; $display("FAIL reset_phase: got %0b want 0", WB_PHASE); end
    checks++; if (WB_DST !== 6'd0) begin errors++; $display("FAIL reset_dst: got %0d want 0", WB_DST); end
    checks++; if (WB_DATA !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", WB_DATA); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", ERR); end
    checks++; if (ISSUE_STALL !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", ISSUE_STALL); end
  endtask

  task automatic test_single();
    do_reset();
    ISSUE_EN = 2'b01; ISSUE_DST0 = 6'd5;
    tick();
    ISSUE_EN = 2'b00;
    tick(); tick();
    checks++; if (WB_VALID !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b want 0", WB_VALID); end
    RES_EN = 2'b01; RES_DATA = 32'h3F000000;
    tick();
    RES_EN = 2'b00; RES_DATA = 32'hDEADBEEF;
    checks++; if (WB_VALID !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", WB_VALID); end
    checks++; if (WB_PHASE !== 1'b0) begin errors++; $display("FAIL single_phase: got %0b want 0", WB_PHASE); end
    checks++; if (WB_DST !== 6'd5) begin errors++; $display("FAIL single_dst: got %0d want 5", WB_DST); end
    checks++; if (WB_DATA !== 32'h3F000000) begin errors++; $display("FAIL single_data: got %h want 3f000000", WB_DATA); end
    WB_READY = 1'b1;
    tick();
    WB_READY = 1'b0;
    checks++; if (WB_VALID !== 1'b0) begin errors++; $display("FAIL single_drain: got %0b want 0", WB_VALID); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL single_err: got %0b want 0", ERR); end
  endtask

  task automatic test_order();
    logic [5:0]  exp_dst [3];
    logic [31:0] exp_dat [3];
    exp_dst[0] = 6'd7; exp_dst[1] = 6'd8; exp_dst[2] = 6'd9;
    exp_dat[0] = 32'hA; exp_dat[1] = 32'hB; exp_dat[2] = 32'hC;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ISSUE_EN = 2'b10; ISSUE_DST1 = exp_dst[i];
      tick();
    end
    ISSUE_EN = 2'b00;
    checks++; if (ISSUE_STALL !== 1'b1) begin errors++; $display("FAIL order_stall3: got %0b want 1", ISSUE_STALL); end
    for (int i = 0; i < 3; i++) begin
      RES_EN = 2'b10; RES_DATA = exp_dat[i];
      tick();
    end
    RES_EN = 2'b00;
    WB_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (WB_VALID !== 1'b1 || WB_PHASE !== 1'b1 || WB_DST !== exp_dst[i] || WB_DATA !== exp_dat[i]) begin
        errors++; $display("FAIL order_wb%0d: got v=%0b ph=%0b dst=%0d data=%h want v=1 ph=1 dst=%0d data=%h",
                           i, WB_VALID, WB_PHASE, WB_DST, WB_DATA, exp_dst[i], exp_dat[i]);
      end
      tick();
    end
    WB_READY = 1'b0;
    checks++; if (WB_VALID !== 1'b0) begin errors++; $display("FAIL order_empty: got %0b want 0", WB_VALID); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      ISSUE_EN = 2'b01; ISSUE_DST0 = 6'(i);
      tick();
      if (i == 2) begin
        checks++; if (ISSUE_STALL !== 1'b0) begin errors++; $display("FAIL bp_stall2: got %0b want 0", ISSUE_STALL); end
      end
    end
    ISSUE_EN = 2'b00;
    checks++; if (ISSUE_STALL !== 1'b1) begin errors++; $display("FAIL bp_stall3: got %0b want 1", ISSUE_STALL); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL bp_err_pre: got %0b want 0", ERR); end
    ISSUE_EN = 2'b01; ISSUE_DST0 = 6'd4;
    tick();
    ISSUE_EN = 2'b00;
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL bp_err_drop: got %0b want 1", ERR); end
    checks++; if (ISSUE_STALL !== 1'b1) begin errors++; $display("FAIL bp_stall_hold: got %0b want 1", ISSUE_STALL); end
    for (int i = 0; i < 3; i++) begin
      RES_EN = 2'b01; RES_DATA = 32'h100 + 32'(i);
      tick();
    end
    RES_EN = 2'b00;
    tick();
    checks++; if (WB_DST !== 6'd1 || WB_DATA !== 32'h100) begin
      errors++; $display("FAIL bp_hold_head: got dst=%0d data=%h want dst=1 data=100", WB_DST, WB_DATA);
    end
    checks++; if (ISSUE_STALL !== 1'b1) begin errors++; $display("FAIL bp_stall_wait: got %0b want 1", ISSUE_STALL); end
    WB_READY = 1'b1;
    tick();
    WB_READY = 1'b0;
    checks++; if (ISSUE_STALL !== 1'b0) begin errors++; $display("FAIL bp_stall_release: got %0b want 0", ISSUE_STALL); end
    checks++; if (WB_DST !== 6'd2 || WB_DATA !== 32'h101) begin
      errors++; $display("FAIL bp_next_head: got dst=%0d data=%h want dst=2 data=101", WB_DST, WB_DATA);
    end
    WB_READY = 1'b1;
    tick();
    checks++; if (WB_DST !== 6'd3 || WB_DATA !== 32'h102) begin
      errors++; $display("FAIL bp_third_head: got dst=%0d data=%h want dst=3 data=102", WB_DST, WB_DATA);
    end
    tick();
    WB_READY = 1'b0;
    RES_EN = 2'b01; RES_DATA = 32'h999;
    tick();
    RES_EN = 2'b00;
    checks++; if (WB_VALID !== 1'b0) begin errors++; $display("FAIL bp_no_dropped_tag: got %0b want 0", WB_VALID); end
  endtask

  task automatic test_dual();
    do_reset();
    ISSUE_EN = 2'b11; ISSUE_DST0 = 6'd2; ISSUE_DST1 = 6'd3;
    tick();
    ISSUE_EN = 2'b00;
    tick();
    RES_EN = 2'b10; RES_DATA = 32'h11;
    tick();
    RES_EN = 2'b01; RES_DATA = 32'h22;
    tick();
    RES_EN = 2'b00;
    checks++; if (WB_VALID !== 1'b1 || WB_PHASE !== 1'b1 || WB_DST !== 6'd3 || WB_DATA !== 32'h11) begin
      errors++; $display("FAIL dual_first: got v=%0b ph=%0b dst=%0d data=%h want v=1 ph=1 dst=3 data=11",
                         WB_VALID, WB_PHASE, WB_DST, WB_DATA);
    end
    WB_READY = 1'b1;
    tick();
    checks++; if (WB_VALID !== 1'b1 || WB_PHASE !== 1'b0 || WB_DST !== 6'd2 || WB_DATA !== 32'h22) begin
      errors++; $display("FAIL dual_second: got v=%0b ph=%0b dst=%0d data=%h want v=1 ph=0 dst=2 data=22",
                         WB_VALID, WB_PHASE, WB_DST, WB_DATA);
    end
    tick();
    WB_READY = 1'b0;
    checks++; if (WB_VALID !== 1'b0 || ERR !== 1'b0) begin
      errors++; $display("FAIL dual_end: got v=%0b err=%0b want v=0 err=0", WB_VALID, ERR);
    end
  endtask

  task automatic test_errors();
    do_reset();
    RES_EN = 2'b01; RES_DATA = 32'h55;
    tick();
    RES_EN = 2'b00;
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL err_orphan_flag: got %0b want 1", ERR); end
    checks++; if (WB_VALID !== 1'b0) begin errors++; $display("FAIL err_orphan_valid: got %0b want 0", WB_VALID); end
    do_reset();
    ISSUE_EN = 2'b11; ISSUE_DST0 = 6'd2; ISSUE_DST1 = 6'd3;
    tick();
    ISSUE_EN = 2'b00;
    RES_EN = 2'b11; RES_DATA = 32'h77;
    tick();
    RES_EN = 2'b00;
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL err_both_flag: got %0b want 1", ERR); end
    checks++; if (WB_VALID !== 1'b1 || WB_PHASE !== 1'b0 || WB_DST !== 6'd2 || WB_DATA !== 32'h77) begin
      errors++; $display("FAIL err_both_entry: got v=%0b ph=%0b dst=%0d data=%h want v=1 ph=0 dst=2 data=77",
                         WB_VALID, WB_PHASE, WB_DST, WB_DATA);
    end
    WB_READY = 1'b1;
    tick();
    WB_READY = 1'b0;
    checks++; if (WB_VALID !== 1'b0) begin errors++; $display("FAIL err_both_single: got %0b want 0", WB_VALID); end
    // the phase-1 tag survived, so a later phase-1 result still pairs with dst 3
    RES_EN = 2'b10; RES_DATA = 32'h88;
    tick();
    RES_EN = 2'b00;
    checks++; if (WB_VALID !== 1'b1 || WB_PHASE !== 1'b1 || WB_DST !== 6'd3 || WB_DATA !== 32'h88) begin
      errors++; $display("FAIL err_ph1_tag_kept: got v=%0b ph=%0b dst=%0d data=%h want v=1 ph=1 dst=3 data=88",
                         WB_VALID, WB_PHASE, WB_DST, WB_DATA);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    RES_EN = 2'b01; RES_DATA = 32'h1;
    tick();
    RES_EN = 2'b00;
    ISSUE_EN = 2'b11; ISSUE_DST0 = 6'd10; ISSUE_DST1 = 6'd11;
    tick();
    ISSUE_EN = 2'b01; ISSUE_DST0 = 6'd12;
    tick();
    ISSUE_EN = 2'b00;
    RES_EN = 2'b01; RES_DATA = 32'h21;
    tick();
    RES_EN = 2'b10; RES_DATA = 32'h22;
    tick();
    RES_EN = 2'b00;
    checks++; if (WB_VALID !== 1'b1 || ERR !== 1'b1 || ISSUE_STALL !== 1'b1) begin
      errors++; $display("FAIL rmid_pre: got v=%0b err=%0b stall=%0b want v=1 err=1 stall=1", WB_VALID, ERR, ISSUE_STALL);
    end
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    checks++; if (WB_VALID !== 1'b0 || ERR !== 1'b0 || ISSUE_STALL !== 1'b0) begin
      errors++; $display("FAIL rmid_post: got v=%0b err=%0b stall=%0b want v=0 err=0 stall=0", WB_VALID, ERR, ISSUE_STALL);
    end
    checks++; if (WB_PHASE !== 1'b0 || WB_DST !== 6'd0 || WB_DATA !== 32'h0) begin
      errors++; $display("FAIL rmid_outs: got ph=%0b dst=%0d data=%h want 0 0 0", WB_PHASE, WB_DST, WB_DATA);
    end
    RES_EN = 2'b01; RES_DATA = 32'h33;
    tick();
    RES_EN = 2'b00;
    checks++; if (WB_VALID !== 1'b0) begin errors++; $display("FAIL rmid_stale_tag: got %0b want 0", WB_VALID); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_backpressure();
    test_dual();
    test_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
